mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Sequencer that sits directly upstream and downstream of the team's 4:1 multiplexer. It drives the mux select `s` through channels 0..3, waits a programmable settle time on each channel and samples the mux output `y`. The four samples are assembled into a 4-bit word, which is delivered to the consumer over a valid/ready handshake. Supports single-shot and continuous scanning, plus synchronous abort.

Parameters:
SETTLE, 1, cycles each select value is held before y is sampled; legal range 1..15
NCH, 4, channels per scan (fixed at 4; mux width)
SELW, 2, select width, equal to log2(NCH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begins a scan; honoured only in IDLE
continuous  input  1  sampled at the handshake edge; 1 starts the next scan automatically
abort  input  1  synchronous abort; returns the block to IDLE
y_in  input  1  mux output y
sel  output  SELW  mux select s, registered
word  output  NCH  assembled word; word[k] is y sampled while sel==k
word_valid  output  1  word is available
word_ready  input  1  consumer accepts word
busy  output  1  state != IDLE
scan_cnt  output  8  count of accepted words; wraps 255->0

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, word=0, word_valid=0, busy=0, scan_cnt=0, settle counter=0.
- States: IDLE, SETTLE, HOLD.
- IDLE: sel=0. If start=1 at an edge, go to SETTLE and load the settle counter with SETTLE-1.
- SETTLE:
  - The counter decrements each edge.
  - At the edge where counter==0: word[sel] <= y_in.
  - If sel<3: sel <= sel+1 and reload the counter to SETTLE-1.
  - If sel==3: sel <= 0, word_valid <= 1, go to HOLD.
  - Each sel value is therefore held exactly SETTLE cycles.
- Latency: word_valid rises 4*SETTLE edges after the start edge.
- HOLD:
  - word and word_valid are stable; no sampling occurs; y_in changes are ignored.
  - At an edge with word_ready=1: word_valid <= 0 and scan_cnt <= scan_cnt+1 (mod 256).
  - After that edge: go to SETTLE (counter=SETTLE-1) if continuous=1, else go to IDLE.
  - word is retained after the handshake until the next scan overwrites its bits.
- word_ready outside HOLD has no effect.
- start outside IDLE is ignored; it is not queued.
- abort=1 at any edge wins over start, sampling and handshake:
  - next state is IDLE; sel=0; word_valid=0; counter=0.
  - word and scan_cnt are unchanged.
  - A pending unaccepted word is discarded and not counted.
- Simultaneous start and abort in IDLE: stay in IDLE.
- Reset mid-scan: all outputs go to reset values immediately. The partial word is lost.
- sel comes straight from a flop (no glitches), so the mux sees a clean select.

Decomposition:
- Package mux_scan_pkg holds:
  - the state enum {IDLE, SETTLE, HOLD};
  - NCH=4 and SELW=2;
  - a 4-bit settle counter width constant.
- One sub-module: settle_timer, a loadable 4-bit down-counter with a zero flag. Everything else (FSM, sel counter, word register, handshake) stays in the top module.
- The bench models the mux ideally as y = i[sel].

Test Plan:
1. rst asserted mid-scan, while sel=2 in SETTLE -> sel=0, word_valid=0, busy=0, scan_cnt=0 without waiting for a clock edge.
2. SETTLE=1, i=4'b1010, start pulse, word_ready=1 -> sel goes 0,1,2,3 on consecutive cycles; word_valid high 4 cycles after the start edge; word=4'b1010; scan_cnt=1; then IDLE and busy=0.
3. Backpressure: word_ready=0 for 5 cycles after valid, with i changed to 4'b0101 during HOLD -> word stays 4'b1010, word_valid stays 1, sel=0; on word_ready=1, scan_cnt increments once.
4. continuous=1, i=4'b0011 for the first scan and 4'b1100 for the second, word_ready=1 -> words 0011 then 1100; second valid 4 cycles after the first handshake edge; scan_cnt=2.
5. SETTLE=3, i=4'b1111 -> each sel value held exactly 3 cycles; valid 12 cycles after start; word=4'b1111.
6. Abort and wrap:
   - abort together with start at sel=1 -> IDLE, sel=0, start ignored, scan_cnt unchanged.
   - 256 completed handshakes -> scan_cnt wraps to 0.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the mux scan sequencer.
// State encoding, channel count and settle counter width live here.
package mux_scan_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StHold   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Mux select/sample and word handshake bundle between the sequencer and its neighbours.
// master is the sequencer side; slave is the mux plus word consumer.
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic [SELW-1:0] sel;
  logic            y_in;
  logic [NCH-1:0]  word;
  logic            word_valid;
  logic            word_ready;

  modport master (
    output sel,
    output word,
    output word_valid,
    input  y_in,
    input  word_ready
  );

  modport slave (
    input  sel,
    input  word,
    input  word_valid,
    output y_in,
    output word_ready
  );

endinterface

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Loadable down-counter that paces how long each select value is held.
// load wins over dec; the count stops at zero rather than wrapping.
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through every channel, samples y after a settle time
// and hands the assembled word to the consumer over valid/ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  output logic                busy,
  output logic [7:0]          scan_cnt,
  mux_scan_sequencer_if.master bus
);

  localparam logic [CNTW-1:0] SettleLd = CNTW'(SETTLE - 1);
  localparam logic [SELW-1:0] LastSel  = SELW'(NCH - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NCH-1:0]  word_q, word_d;
  logic            valid_q, valid_d;
  logic [7:0]      scan_cnt_q, scan_cnt_d;

  logic            tmr_load;
  logic [CNTW-1:0] tmr_val;
  logic            tmr_dec;
  logic            tmr_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    word_d     = word_q;
    valid_d    = valid_q;
    scan_cnt_d = scan_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = SettleLd;
    tmr_dec    = 1'b0;

    // abort outranks start, sampling and the handshake; word and scan_cnt survive it
    if (abort) begin
      state_d  = StIdle;
      sel_d    = '0;
      valid_d  = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sel_d = '0;
          if (start) begin
            state_d  = StSettle;
            tmr_load = 1'b1;
          end
        end

        StSettle: begin
          if (tmr_zero) begin
            word_d[sel_q] = bus.y_in;
            if (sel_q != LastSel) begin
              sel_d    = sel_q + SELW'(1);
              tmr_load = 1'b1;
            end else begin
              sel_d   = '0;
              valid_d = 1'b1;
              state_d = StHold;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end

        StHold: begin
          if (bus.word_ready) begin
            valid_d    = 1'b0;
            scan_cnt_d = scan_cnt_q + 8'd1;
            if (continuous) begin
              state_d  = StSettle;
              tmr_load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end

        default: begin
          state_d = StIdle;
          sel_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  // sel is driven straight from its flop so the mux never sees a decode glitch
  assign bus.sel        = sel_q;
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign busy           = (state_q != StIdle);
  assign scan_cnt       = scan_cnt_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with an ideal mux model y = i[sel].
// Two instances: SETTLE=1 (u_dut1) and SETTLE=3 (u_dut3).
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start1, cont1, abort1;
  logic       start3, cont3, abort3;
  logic       busy1, busy3;
  logic [7:0] cnt1, cnt3;
  logic [3:0] i1, i3;

  int vectors;
  int miscompares;

  mux_scan_sequencer_if bus1 ();
  mux_scan_sequencer_if bus3 ();

  assign bus1.y_in = i1[bus1.sel];
  assign bus3.y_in = i3[bus3.sel];

  mux_scan_sequencer #(.SETTLE(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .continuous (cont1),
    .abort      (abort1),
    .busy       (busy1),
    .scan_cnt   (cnt1),
    .bus        (bus1)
  );

  mux_scan_sequencer #(.SETTLE(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .continuous (cont3),
    .abort      (abort3),
    .busy       (busy3),
    .scan_cnt   (cnt3),
    .bus        (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    start1 = 1'b0; cont1 = 1'b0; abort1 = 1'b0; i1 = 4'b0000;
    start3 = 1'b0; cont3 = 1'b0; abort3 = 1'b0; i3 = 4'b0000;
    bus1.word_ready = 1'b0;
    bus3.word_ready = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_sel",   32'(bus1.sel), 32'd0);
    chk("rst_valid", 32'(bus1.word_valid), 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_cnt",   32'(cnt1), 32'd0);
    chk("rst_word",  32'(bus1.word), 32'd0);

    // Single scan, SETTLE=1, i=1010, ready high
    i1 = 4'b1010; bus1.word_ready = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("s1_busy", 32'(busy1), 32'd1);
    chk("s1_sel0", 32'(bus1.sel), 32'd0);
    tick(); chk("s1_sel1", 32'(bus1.sel), 32'd1);
    tick(); chk("s1_sel2", 32'(bus1.sel), 32'd2);
    tick(); chk("s1_sel3", 32'(bus1.sel), 32'd3);
    chk("s1_novalid", 32'(bus1.word_valid), 32'd0);
    tick();
    chk("s1_valid", 32'(bus1.word_valid), 32'd1);
    chk("s1_word",  32'(bus1.word), 32'hA);
    chk("s1_selh",  32'(bus1.sel), 32'd0);
    tick();
    chk("s1_vdrop", 32'(bus1.word_valid), 32'd0);
    chk("s1_cnt",   32'(cnt1), 32'd1);
    chk("s1_idle",  32'(busy1), 32'd0);

    // Backpressure with y changing during HOLD
    bus1.word_ready = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    chk("bp_valid", 32'(bus1.word_valid), 32'd1);
    i1 = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(bus1.word_valid), 32'd1);
      chk("bp_hold_word",  32'(bus1.word), 32'hA);
      chk("bp_hold_sel",   32'(bus1.sel), 32'd0);
      chk("bp_hold_cnt",   32'(cnt1), 32'd1);
    end
    bus1.word_ready = 1'b1;
    tick();
    chk("bp_cnt",   32'(cnt1), 32'd2);
    chk("bp_vdrop", 32'(bus1.word_valid), 32'd0);
    chk("bp_idle",  32'(busy1), 32'd0);
    tick();
    chk("bp_cnt_stay", 32'(cnt1), 32'd2);

    // Continuous: 0011 then 1100
    cont1 = 1'b1; i1 = 4'b0011; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    chk("ct_valid1", 32'(bus1.word_valid), 32'd1);
    chk("ct_word1",  32'(bus1.word), 32'h3);
    i1 = 4'b1100;
    tick();
    cont1 = 1'b0;
    chk("ct_hs1_valid", 32'(bus1.word_valid), 32'd0);
    chk("ct_hs1_cnt",   32'(cnt1), 32'd3);
    chk("ct_hs1_busy",  32'(busy1), 32'd1);
    chk("ct_hs1_word",  32'(bus1.word), 32'h3);
    repeat (3) tick();
    chk("ct_novalid", 32'(bus1.word_valid), 32'd0);
    tick();
    chk("ct_valid2", 32'(bus1.word_valid), 32'd1);
    chk("ct_word2",  32'(bus1.word), 32'hC);
    tick();
    chk("ct_cnt2", 32'(cnt1), 32'd4);
    chk("ct_idle", 32'(busy1), 32'd0);

    // Abort together with start at sel=1
    i1 = 4'b1111; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("ab_sel1", 32'(bus1.sel), 32'd1);
    abort1 = 1'b1; start1 = 1'b1;
    tick();
    abort1 = 1'b0; start1 = 1'b0;
    chk("ab_busy",  32'(busy1), 32'd0);
    chk("ab_sel",   32'(bus1.sel), 32'd0);
    chk("ab_valid", 32'(bus1.word_valid), 32'd0);
    chk("ab_cnt",   32'(cnt1), 32'd4);
    chk("ab_word",  32'(bus1.word), 32'hD);
    tick();
    chk("ab_noqueue", 32'(busy1), 32'd0);

    // Abort in HOLD drops the pending word uncounted
    bus1.word_ready = 1'b0; i1 = 4'b0000; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    chk("abh_valid", 32'(bus1.word_valid), 32'd1);
    abort1 = 1'b1; bus1.word_ready = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abh_vdrop", 32'(bus1.word_valid), 32'd0);
    chk("abh_cnt",   32'(cnt1), 32'd4);
    chk("abh_busy",  32'(busy1), 32'd0);
    chk("abh_word",  32'(bus1.word), 32'h0);

    // Async reset while sel=2 in SETTLE
    i1 = 4'b1111; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    chk("ar_pre_sel", 32'(bus1.sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_sel",   32'(bus1.sel), 32'd0);
    chk("ar_valid", 32'(bus1.word_valid), 32'd0);
    chk("ar_busy",  32'(busy1), 32'd0);
    chk("ar_cnt",   32'(cnt1), 32'd0);
    chk("ar_word",  32'(bus1.word), 32'd0);
    rst = 1'b0;
    tick();

    // SETTLE=3: each sel held 3 cycles, valid 12 edges after start
    i3 = 4'b1111; bus3.word_ready = 1'b1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("s3_sel",   32'(bus3.sel), 32'(k / 3));
      chk("s3_valid", 32'(bus3.word_valid), 32'd0);
      tick();
    end
    chk("s3_valid_up", 32'(bus3.word_valid), 32'd1);
    chk("s3_word",     32'(bus3.word), 32'hF);
    chk("s3_sel_h",    32'(bus3.sel), 32'd0);
    tick();
    chk("s3_cnt",  32'(cnt3), 32'd1);
    chk("s3_idle", 32'(busy3), 32'd0);

    // 256 handshakes wrap scan_cnt
    bus1.word_ready = 1'b1; cont1 = 1'b0; i1 = 4'b0110;
    for (int n = 0; n < 256; n++) begin
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (5) tick();
      if (n == 254) chk("wr_255", 32'(cnt1), 32'd255);
    end
    chk("wr_0",    32'(cnt1), 32'd0);
    chk("wr_word", 32'(bus1.word), 32'h6);
    chk("wr_idle", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
